// File: rtl/pc_sequencer.sv
// Program-counter unit: next-PC selection from a 3-bit mode code plus a circular
// return-address stack for call/return.
module pc_sequencer #(
  parameter int unsigned     PC_W      = 64,
  parameter int unsigned     OFF_W     = 26,
  parameter int unsigned     STEP      = 4,
  parameter int unsigned     SHIFT     = 2,
  parameter int unsigned     DEPTH     = 4,
  parameter logic [PC_W-1:0] RESET_VEC = '0
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Stall,
  input  logic [2:0]       Mode,
  input  logic             Zero,
  input  logic [OFF_W-1:0] Offset,
  input  logic [PC_W-1:0]  RegTarget,
  output logic [PC_W-1:0]  PC,
  output logic [PC_W-1:0]  PCPlus,
  output logic             Taken,
  output logic             RasEmpty,
  output logic             RasFull,
  output logic             RasOvf,
  output logic             RasUnf
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [2:0] {
    ModeSeq  = 3'd0,
    ModeCbz  = 3'd1,
    ModeCbnz = 3'd2,
    ModeB    = 3'd3,
    ModeBl   = 3'd4,
    ModeBr   = 3'd5,
    ModeRet  = 3'd6,
    ModeRsvd = 3'd7
  } mode_e;

  mode_e           mode;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            taken_q, taken_d;
  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] top_q, top_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic            push;
  logic [PC_W-1:0] ras_q [DEPTH];

  logic [PC_W-1:0] off_ext;
  logic [PC_W-1:0] bt;
  logic [PC_W-1:0] pc_plus;
  logic [PtrW-1:0] top_m1;
  logic            ras_empty;
  logic            ras_full;

  assign mode      = mode_e'(Mode);
  assign off_ext   = {{(PC_W-OFF_W){Offset[OFF_W-1]}}, Offset};
  assign bt        = pc_q + (off_ext << SHIFT);
  assign pc_plus   = pc_q + PC_W'(STEP);
  // top_q names the next free slot; the newest entry sits just below it.
  assign top_m1    = top_q - PtrW'(1);
  assign ras_empty = (count_q == '0);
  assign ras_full  = (count_q == CntW'(DEPTH));

  always_comb begin
    pc_d    = pc_q;
    taken_d = 1'b0;
    count_d = count_q;
    top_d   = top_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push    = 1'b0;
    if (!Stall) begin
      pc_d = pc_plus;
      case (mode)
        ModeCbz: begin
          if (Zero) begin
            pc_d    = bt;
            taken_d = 1'b1;
          end
        end
        ModeCbnz: begin
          if (!Zero) begin
            pc_d    = bt;
            taken_d = 1'b1;
          end
        end
        ModeB: begin
          pc_d    = bt;
          taken_d = 1'b1;
        end
        ModeBl: begin
          pc_d    = bt;
          taken_d = 1'b1;
          push    = 1'b1;
          top_d   = top_q + PtrW'(1);
          // When full the write lands on the oldest slot, so count saturates.
          if (ras_full) ovf_d = 1'b1;
          else          count_d = count_q + CntW'(1);
        end
        ModeBr: begin
          pc_d    = RegTarget;
          taken_d = 1'b1;
        end
        ModeRet: begin
          if (!ras_empty) begin
            pc_d    = ras_q[top_m1];
            taken_d = 1'b1;
            top_d   = top_m1;
            count_d = count_q - CntW'(1);
          end else begin
            unf_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      pc_q    <= RESET_VEC;
      taken_q <= 1'b0;
      count_q <= '0;
      top_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      taken_q <= taken_d;
      count_q <= count_d;
      top_q   <= top_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset && push) ras_q[top_q] <= pc_plus;
  end

  assign PC       = pc_q;
  assign PCPlus   = pc_plus;
  assign Taken    = taken_q;
  assign RasEmpty = ras_empty;
  assign RasFull  = ras_full;
  assign RasOvf   = ovf_q;
  assign RasUnf   = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a queue-based behavioural model.
module tb_pc_sequencer;

  logic        Clock = 1'b0;
  logic        Reset, Stall, Zero;
  logic [2:0]  Mode;
  logic [25:0] Offset;
  logic [63:0] RegTarget;
  logic [63:0] PC, PCPlus;
  logic        Taken, RasEmpty, RasFull, RasOvf, RasUnf;

  int checks = 0;
  int errors = 0;

  pc_sequencer dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Stall     (Stall),
    .Mode      (Mode),
    .Zero      (Zero),
    .Offset    (Offset),
    .RegTarget (RegTarget),
    .PC        (PC),
    .PCPlus    (PCPlus),
    .Taken     (Taken),
    .RasEmpty  (RasEmpty),
    .RasFull   (RasFull),
    .RasOvf    (RasOvf),
    .RasUnf    (RasUnf)
  );

  always #5 Clock = ~Clock;

  // Behavioural model: the RAS is a bounded queue, newest entry at the back.
  logic [63:0] m_pc;
  logic        m_taken, m_ovf, m_unf;
  logic        m_valid = 1'b0;
  logic [63:0] m_ras[$];

  always @(posedge Clock) begin
    longint      off;
    logic [63:0] bt;
    off = longint'($signed(Offset));
    bt  = m_pc + 64'(off * 4);
    if (Reset) begin
      m_pc = 64'h0; m_taken = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
      m_ras.delete();
      m_valid = 1'b1;
    end else if (Stall) begin
      m_taken = 1'b0;
    end else begin
      m_taken = 1'b0;
      case (Mode)
        3'd1: if (Zero)  begin m_pc = bt; m_taken = 1'b1; end else m_pc = m_pc + 64'd4;
        3'd2: if (!Zero) begin m_pc = bt; m_taken = 1'b1; end else m_pc = m_pc + 64'd4;
        3'd3: begin m_pc = bt; m_taken = 1'b1; end
        3'd4: begin
          m_ras.push_back(m_pc + 64'd4);
          if (m_ras.size() > 4) begin
            void'(m_ras.pop_front());
            m_ovf = 1'b1;
          end
          m_pc = bt; m_taken = 1'b1;
        end
        3'd5: begin m_pc = RegTarget; m_taken = 1'b1; end
        3'd6: begin
          if (m_ras.size() > 0) begin
            m_pc = m_ras.pop_back(); m_taken = 1'b1;
          end else begin
            m_pc = m_pc + 64'd4; m_unf = 1'b1;
          end
        end
        default: m_pc = m_pc + 64'd4;
      endcase
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clock) begin
    if (m_valid) begin
      check("pc", PC, m_pc);
      check("pc_plus", PCPlus, m_pc + 64'd4);
      check("taken", 64'(Taken), 64'(m_taken));
      check("ras_empty", 64'(RasEmpty), 64'(m_ras.size() == 0));
      check("ras_full", 64'(RasFull), 64'(m_ras.size() == 4));
      check("ras_ovf", 64'(RasOvf), 64'(m_ovf));
      check("ras_unf", 64'(RasUnf), 64'(m_unf));
    end
  end

  task automatic step(input logic rst, input logic stl, input logic [2:0] md,
                      input logic z, input logic [25:0] off, input logic [63:0] tgt);
    Reset = rst; Stall = stl; Mode = md; Zero = z; Offset = off; RegTarget = tgt;
    @(negedge Clock);
  endtask

  initial begin
    Reset = 1'b1; Stall = 1'b0; Mode = 3'd0; Zero = 1'b0; Offset = '0; RegTarget = '0;
    @(negedge Clock);
    check("reset_pc", PC, 64'h0);
    check("reset_taken", 64'(Taken), 64'h0);
    check("reset_empty", 64'(RasEmpty), 64'h1);

    // Sequential run
    for (int i = 0; i < 9; i++) begin
      step(0, 0, 3'd0, 0, '0, '0);
      check("seq_pc", PC, 64'(4 * (i + 1)));
      check("seq_taken", 64'(Taken), 64'h0);
    end
    check("seq_empty", 64'(RasEmpty), 64'h1);

    // Conditional branches
    step(0, 0, 3'd5, 0, '0, 64'h20);
    step(0, 0, 3'd1, 1, 26'(-2), '0);
    check("cbz_taken_pc", PC, 64'h18);
    check("cbz_taken_t", 64'(Taken), 64'h1);
    step(0, 0, 3'd5, 0, '0, 64'h20);
    step(0, 0, 3'd1, 0, 26'(-2), '0);
    check("cbz_nt_pc", PC, 64'h24);
    check("cbz_nt_t", 64'(Taken), 64'h0);
    step(0, 0, 3'd2, 0, 26'(-2), '0);
    check("cbnz_pc", PC, 64'h1C);
    check("cbnz_t", 64'(Taken), 64'h1);

    // Call, return, register jump
    step(0, 0, 3'd5, 0, '0, 64'h100);
    step(0, 0, 3'd4, 0, 26'h10, '0);
    check("bl_pc", PC, 64'h140);
    check("bl_model_top", m_ras[$], 64'h104);
    check("bl_not_empty", 64'(RasEmpty), 64'h0);
    step(0, 0, 3'd6, 0, '0, '0);
    check("ret_pc", PC, 64'h104);
    check("ret_empty", 64'(RasEmpty), 64'h1);
    step(0, 0, 3'd5, 0, '0, 64'hDEAD0);
    check("br_pc", PC, 64'hDEAD0);

    // Overflow then underflow
    for (int i = 0; i < 5; i++) step(0, 0, 3'd4, 0, 26'h40, '0);
    check("ovf_pc", PC, 64'hDEFD0);
    check("ovf_full", 64'(RasFull), 64'h1);
    check("ovf_flag", 64'(RasOvf), 64'h1);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 3'd6, 0, '0, '0);
      check("ret_chain_pc", PC, 64'hDEAD4 + 64'((4 - k) * 'h100));
    end
    step(0, 0, 3'd6, 0, '0, '0);
    check("unf_flag", 64'(RasUnf), 64'h1);
    check("unf_pc", PC, 64'hDEBD8);
    check("unf_taken", 64'(Taken), 64'h0);

    // Stall, then reset during stall
    step(0, 0, 3'd4, 0, 26'h40, '0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 3'd3, 0, 26'h5, '0);
      check("stall_pc", PC, 64'hDECD8);
      check("stall_taken", 64'(Taken), 64'h0);
      check("stall_empty", 64'(RasEmpty), 64'h0);
    end
    step(1, 1, 3'd3, 0, 26'h5, '0);
    check("rst_stall_pc", PC, 64'h0);
    check("rst_stall_ovf", 64'(RasOvf), 64'h0);
    check("rst_stall_unf", 64'(RasUnf), 64'h0);
    check("rst_stall_empty", 64'(RasEmpty), 64'h1);

    // Wrap-around
    step(0, 0, 3'd5, 0, '0, 64'hFFFF_FFFF_FFFF_FFFC);
    step(0, 0, 3'd0, 0, '0, '0);
    check("wrap_seq", PC, 64'h0);
    step(0, 0, 3'd5, 0, '0, 64'h8);
    step(0, 0, 3'd3, 0, 26'(-4), '0);
    check("wrap_b", PC, 64'hFFFF_FFFF_FFFF_FFF8);

    // Randomized run
    for (int i = 0; i < 3000; i++) begin
      logic [25:0] off;
      off = ($urandom_range(0, 3) == 0) ? 26'($urandom) : 26'(int'($urandom_range(0, 64)) - 32);
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) == 0), 3'($urandom_range(0, 7)),
           1'($urandom), off, {$urandom, $urandom});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
